alu_seq_core: RTL and testbench

ALU_SEQ_CORE -- requirements
Module: alu_seq_core

---
 rtl/alu_seq_core.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_alu_seq_core.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_core.sv
// Sequential ALU core: gathers operands over one or more cycles, executes one command and posts a single result.
// Define ALU_MUL_EN to build the two-cycle multiply path (arithmetic commands 9 and 10).
module alu_seq_core #(
    parameter int WIDTH   = 8,
    parameter int CWIDTH  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 mode,
    input  logic [CWIDTH-1:0]    cmd,
    input  logic [1:0]           inp_valid,
    input  logic [WIDTH-1:0]     opa,
    input  logic [WIDTH-1:0]     opb,
    input  logic                 cin,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   res,
    output logic                 res_valid,
    output logic                 cout,
    output logic                 oflow,
    output logic                 g,
    output logic                 l,
    output logic                 e,
    output logic                 err
);

    localparam int RW = 2 * WIDTH;
    localparam int SW = $clog2(WIDTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]  TMR_ONE  = TW'(1);
    localparam logic [WIDTH:0] ONE_X    = (WIDTH + 1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_A, S_WAIT_B, S_EXEC, S_MUL2} state_t;
    state_t state, state_nx;

    logic              mode_p0, cin_p0;
    logic [CWIDTH-1:0] cmd_p0;
    logic [WIDTH-1:0]  a_p0, b_p0;
    logic [TW-1:0]     tmr;

    logic [1:0] need;
    logic       cap_cmd, cap_a, cap_b, tmr_clr, tmr_inc, ld_res, ld_tmo, is_mul;

    // Returns {need_b, need_a} for a command.
    function automatic logic [1:0] need_ops(input logic m, input logic [CWIDTH-1:0] c);
        logic [1:0] n;
        n = 2'b11;
        if (m) begin
            case (int'(c))
                4, 5:    n = 2'b01;
                6, 7:    n = 2'b10;
                default: n = 2'b11;
            endcase
        end else begin
            case (int'(c))
                6, 8, 9:   n = 2'b01;
                7, 10, 11: n = 2'b10;
                default:   n = 2'b11;
            endcase
        end
        return n;
    endfunction

    assign need  = need_ops(mode, cmd);
    assign ready = (state == S_IDLE) || (state == S_WAIT_A) || (state == S_WAIT_B);

    // Datapath operating on the captured operands
    logic [WIDTH:0]          a_x, b_x, cin_x;
    logic [WIDTH:0]          add_ab, sub_ab, addc_ab, subc_ab, inc_a, dec_a, inc_b, dec_b;
    logic signed [WIDTH-1:0] sa, sb, ssum, sdif;
    logic [SW-1:0]           rot_sh;
    logic [WIDTH-1:0]        rot_l, rot_r;
    logic                    rot_bad;

    assign a_x     = {1'b0, a_p0};
    assign b_x     = {1'b0, b_p0};
    assign cin_x   = {{WIDTH{1'b0}}, cin_p0};
    assign add_ab  = a_x + b_x;
    assign sub_ab  = a_x - b_x;
    assign addc_ab = a_x + b_x + cin_x;
    assign subc_ab = a_x - b_x - cin_x;
    assign inc_a   = a_x + ONE_X;
    assign dec_a   = a_x - ONE_X;
    assign inc_b   = b_x + ONE_X;
    assign dec_b   = b_x - ONE_X;
    assign sa      = signed'(a_p0);
    assign sb      = signed'(b_p0);
    assign ssum    = sa + sb;
    assign sdif    = sa - sb;
    assign rot_sh  = b_p0[SW-1:0];
    assign rot_l   = (a_p0 << rot_sh) | (a_p0 >> (WIDTH - int'(rot_sh)));
    assign rot_r   = (a_p0 >> rot_sh) | (a_p0 << (WIDTH - int'(rot_sh)));
    assign rot_bad = |b_p0[WIDTH-1:SW];

`ifdef ALU_MUL_EN
    logic [RW-1:0] mul_inc, mul_shl, prod_p1;
    logic          ld_prod, ld_mul;

    assign mul_inc = RW'(inc_a) * RW'(inc_b);
    assign mul_shl = RW'({a_p0, 1'b0}) * RW'(b_p0);
    assign is_mul  = mode_p0 && ((cmd_p0 == CWIDTH'(9)) || (cmd_p0 == CWIDTH'(10)));
    assign ld_prod = (state == S_EXEC) && is_mul;
`else
    assign is_mul  = 1'b0;
`endif

    logic [RW-1:0]    alu_res;
    logic [WIDTH-1:0] lg;
    logic             alu_cout, alu_oflow, alu_g, alu_l, alu_e, alu_err;

    always_comb begin
        alu_res   = '0;
        lg        = '0;
        alu_cout  = 1'b0;
        alu_oflow = 1'b0;
        alu_g     = 1'b0;
        alu_l     = 1'b0;
        alu_e     = 1'b0;
        alu_err   = 1'b0;
        if (mode_p0) begin
            case (int'(cmd_p0))
                0: begin alu_res = RW'(add_ab);  alu_cout  = add_ab[WIDTH];  end
                1: begin alu_res = RW'(sub_ab);  alu_oflow = sub_ab[WIDTH];  end
                2: begin alu_res = RW'(addc_ab); alu_cout  = addc_ab[WIDTH]; end
                3: begin alu_res = RW'(subc_ab); alu_oflow = subc_ab[WIDTH]; end
                4: begin alu_res = RW'(inc_a);   alu_cout  = inc_a[WIDTH];   end
                5: begin alu_res = RW'(dec_a);   alu_oflow = dec_a[WIDTH];   end
                6: begin alu_res = RW'(inc_b);   alu_cout  = inc_b[WIDTH];   end
                7: begin alu_res = RW'(dec_b);   alu_oflow = dec_b[WIDTH];   end
                8: begin
                    alu_g = a_p0 > b_p0;
                    alu_l = a_p0 < b_p0;
                    alu_e = a_p0 == b_p0;
                end
`ifdef ALU_MUL_EN
                9:  alu_res = mul_inc;
                10: alu_res = mul_shl;
`endif
                11: begin
                    alu_res   = {{WIDTH{ssum[WIDTH-1]}}, ssum};
                    alu_oflow = (sa[WIDTH-1] == sb[WIDTH-1]) && (ssum[WIDTH-1] != sa[WIDTH-1]);
                end
                12: begin
                    alu_res   = {{WIDTH{sdif[WIDTH-1]}}, sdif};
                    alu_oflow = (sa[WIDTH-1] != sb[WIDTH-1]) && (sdif[WIDTH-1] != sa[WIDTH-1]);
                end
                default: alu_err = 1'b1;
            endcase
        end else begin
            case (int'(cmd_p0))
                0:  lg = a_p0 & b_p0;
                1:  lg = ~(a_p0 & b_p0);
                2:  lg = a_p0 | b_p0;
                3:  lg = ~(a_p0 | b_p0);
                4:  lg = a_p0 ^ b_p0;
                5:  lg = ~(a_p0 ^ b_p0);
                6:  lg = ~a_p0;
                7:  lg = ~b_p0;
                8:  lg = a_p0 >> 1;
                9:  lg = a_p0 << 1;
                10: lg = b_p0 >> 1;
                11: lg = b_p0 << 1;
                12: if (rot_bad) alu_err = 1'b1; else lg = rot_l;
                13: if (rot_bad) alu_err = 1'b1; else lg = rot_r;
                default: alu_err = 1'b1;
            endcase
            alu_res = {{WIDTH{1'b0}}, lg};
        end
    end

    // Control: next state and register strobes
    always_comb begin
        state_nx = state;
        cap_cmd  = 1'b0;
        cap_a    = 1'b0;
        cap_b    = 1'b0;
        tmr_clr  = 1'b0;
        tmr_inc  = 1'b0;
        ld_res   = 1'b0;
        ld_tmo   = 1'b0;
`ifdef ALU_MUL_EN
        ld_mul   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                tmr_clr = 1'b1;
                if (need == 2'b11) begin
                    cap_cmd = |inp_valid;
                    cap_a   = inp_valid[0];
                    cap_b   = inp_valid[1];
                    case (inp_valid)
                        2'b11:   state_nx = S_EXEC;
                        2'b01:   state_nx = S_WAIT_B;
                        2'b10:   state_nx = S_WAIT_A;
                        default: state_nx = S_IDLE;
                    endcase
                end else if ((inp_valid & need) == need) begin
                    cap_cmd  = 1'b1;
                    cap_a    = inp_valid[0];
                    cap_b    = inp_valid[1];
                    state_nx = S_EXEC;
                end
            end
            S_WAIT_A, S_WAIT_B: begin
                if ((state == S_WAIT_A) ? inp_valid[0] : inp_valid[1]) begin
                    cap_a    = (state == S_WAIT_A);
                    cap_b    = (state == S_WAIT_B);
                    tmr_clr  = 1'b1;
                    state_nx = S_EXEC;
                end else if (tmr == TMR_LAST) begin
                    ld_tmo   = 1'b1;
                    tmr_clr  = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    tmr_inc  = 1'b1;
                end
            end
            S_EXEC: begin
                if (is_mul) begin
                    state_nx = S_MUL2;
                end else begin
                    ld_res   = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_MUL2: begin
`ifdef ALU_MUL_EN
                ld_mul   = 1'b1;
`endif
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else if (ce) state <= state_nx;
    end

    // Capture stage (p0) and result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_p0   <= 1'b0;
            cmd_p0    <= '0;
            cin_p0    <= 1'b0;
            a_p0      <= '0;
            b_p0      <= '0;
            tmr       <= '0;
            res       <= '0;
            res_valid <= 1'b0;
            cout      <= 1'b0;
            oflow     <= 1'b0;
            g         <= 1'b0;
            l         <= 1'b0;
            e         <= 1'b0;
            err       <= 1'b0;
        end else if (ce) begin
            res_valid <= 1'b0;
            if (cap_cmd) begin
                mode_p0 <= mode;
                cmd_p0  <= cmd;
                cin_p0  <= cin;
            end
            if (cap_a) a_p0 <= opa;
            if (cap_b) b_p0 <= opb;
            if (tmr_clr) tmr <= '0;
            else if (tmr_inc) tmr <= tmr + TMR_ONE;
            if (ld_res) begin
                res       <= alu_res;
                cout      <= alu_cout;
                oflow     <= alu_oflow;
                g         <= alu_g;
                l         <= alu_l;
                e         <= alu_e;
                err       <= alu_err;
                res_valid <= 1'b1;
            end else if (ld_tmo) begin
                res       <= '0;
                {cout, oflow, g, l, e} <= '0;
                err       <= 1'b1;
                res_valid <= 1'b1;
            end
`ifdef ALU_MUL_EN
            else if (ld_mul) begin
                res       <= prod_p1;
                {cout, oflow, g, l, e, err} <= '0;
                res_valid <= 1'b1;
            end
`endif
        end
    end

`ifdef ALU_MUL_EN
    // Multiply stage (p1): product settles one cycle ahead of the result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prod_p1 <= '0;
        else if (ce && ld_prod) prod_p1 <= alu_res;
    end
`endif

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core: directed scenarios plus randomized operations against an integer reference model.
module tb_alu_seq_core;

    localparam int W = 8;
`ifdef ALU_MUL_EN
    localparam bit MUL = 1'b1;
`else
    localparam bit MUL = 1'b0;
`endif

    logic           clk, rst, ce, mode, cin;
    logic [3:0]     cmd;
    logic [1:0]     inp_valid;
    logic [W-1:0]   opa, opb;
    logic           ready, res_valid, cout, oflow, g, l, e, err;
    logic [2*W-1:0] res;

    int errors = 0;
    int checks = 0;

    alu_seq_core #(.WIDTH(W), .CWIDTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .ce(ce), .mode(mode), .cmd(cmd), .inp_valid(inp_valid),
        .opa(opa), .opb(opb), .cin(cin), .ready(ready), .res(res), .res_valid(res_valid),
        .cout(cout), .oflow(oflow), .g(g), .l(l), .e(e), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic [5:0]  flags;   // {cout, oflow, g, l, e, err}
        logic [1:0]  lat;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        mode = 1'($urandom);
        cmd  = 4'($urandom);
        cin  = 1'($urandom);
        opa  = 8'($urandom);
        opb  = 8'($urandom);
    endtask

    function automatic bit [1:0] need_of(input bit m, input int c);
        if (m && (c == 4 || c == 5)) return 2'b01;
        if (m && (c == 6 || c == 7)) return 2'b10;
        if (!m && (c == 6 || c == 8 || c == 9)) return 2'b01;
        if (!m && (c == 7 || c == 10 || c == 11)) return 2'b10;
        return 2'b11;
    endfunction

    function automatic int sx8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Reference model: integer arithmetic on the operand values
    function automatic exp_t model(input bit m, input int c, input bit ci, input int a, input int b);
        exp_t x;
        int r, s, sh;
        bit co, ov, gg, ll, ee, er;
        r = 0; co = 0; ov = 0; gg = 0; ll = 0; ee = 0; er = 0;
        x.lat = 2'd1;
        if (m) begin
            case (c)
                0:  begin r = a + b;           co = r > 255; end
                1:  begin r = (a - b) & 'h1FF; ov = a < b; end
                2:  begin r = a + b + ci;      co = r > 255; end
                3:  begin r = (a - b - ci) & 'h1FF; ov = a < b + ci; end
                4:  begin r = a + 1;           co = r > 255; end
                5:  begin r = (a - 1) & 'h1FF; ov = a == 0; end
                6:  begin r = b + 1;           co = r > 255; end
                7:  begin r = (b - 1) & 'h1FF; ov = b == 0; end
                8:  begin gg = a > b; ll = a < b; ee = a == b; end
                9:  if (MUL) begin r = ((a + 1) * (b + 1)) & 'hFFFF; x.lat = 2'd2; end else er = 1;
                10: if (MUL) begin r = ((a * 2) * b) & 'hFFFF; x.lat = 2'd2; end else er = 1;
                11, 12: begin
                    s  = (c == 11) ? sx8(a) + sx8(b) : sx8(a) - sx8(b);
                    ov = (s > 127) || (s < -128);
                    r  = s & 255;
                    if (r >= 128) r = r + 'hFF00;
                end
                default: er = 1;
            endcase
        end else begin
            case (c)
                0:  r = a & b;
                1:  r = ~(a & b) & 255;
                2:  r = a | b;
                3:  r = ~(a | b) & 255;
                4:  r = a ^ b;
                5:  r = ~(a ^ b) & 255;
                6:  r = ~a & 255;
                7:  r = ~b & 255;
                8:  r = a >> 1;
                9:  r = (a << 1) & 255;
                10: r = b >> 1;
                11: r = (b << 1) & 255;
                12, 13: begin
                    if (b >= W) er = 1;
                    else begin
                        sh = b;
                        if (c == 12) r = ((a << sh) | (a >> (W - sh))) & 255;
                        else         r = ((a >> sh) | (a << (W - sh))) & 255;
                    end
                end
                default: er = 1;
            endcase
        end
        if (er) r = 0;
        x.res   = 16'(r);
        x.flags = {co, ov, gg, ll, ee, er};
        return x;
    endfunction

    // split: 0 = operands together, 1 = opa first, 2 = opb first; gap = idle cycles while waiting
    task automatic do_op(input string tag, input bit m, input int c, input bit ci, input int a,
                         input int b, input int split, input int gap);
        exp_t x;
        int   lat, sp;
        bit [1:0] nd;
        x  = model(m, c, ci, a, b);
        nd = need_of(m, c);
        sp = (nd == 2'b11) ? split : 0;
        mode = m; cmd = 4'(c); cin = ci; opa = 8'(a); opb = 8'(b);
        case (sp)
            1:       inp_valid = 2'b01;
            2:       inp_valid = 2'b10;
            default: inp_valid = nd | 2'($urandom);
        endcase
        step();
        if (sp != 0) begin
            for (int i = 0; i < gap; i++) begin
                junk();
                inp_valid = 2'b00;
                step();
            end
            check({tag, "_wait_ready"}, 32'(ready), 32'd1);
            junk();
            if (sp == 1) opb = 8'(b); else opa = 8'(a);
            inp_valid = 2'b11;
            step();
        end
        junk();
        inp_valid = 2'b00;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!res_valid && lat < 4);
        check({tag, "_latency"}, 32'(lat), 32'(x.lat));
        check({tag, "_res"}, 32'(res), 32'(x.res));
        check({tag, "_flags"}, 32'({cout, oflow, g, l, e, err}), 32'(x.flags));
        step();
        check({tag, "_rv_drop"}, 32'(res_valid), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        rst = 1'b0; ce = 1'b1; mode = 1'b0; cmd = '0; cin = 1'b0;
        inp_valid = 2'b00; opa = '0; opb = '0;
        step();
        step();
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_rv", 32'(res_valid), 32'd0);
        check("reset_res", 32'(res), 32'd0);
        check("reset_flags", 32'({cout, oflow, g, l, e, err}), 32'd0);
        rst = 1'b1;

        do_op("add_ff_01", 1'b1, 0, 1'b0, 'hFF, 'h01, 0, 0);
        check("add_ff_01_const", 32'({res, cout}), 32'h0201);

        do_op("sub_wait", 1'b1, 1, 1'b0, 'h05, 'h07, 1, 3);
        check("sub_wait_const", 32'({res, oflow}), 32'h03FD);

        // ce low holds res_valid and res
        mode = 1'b1; cmd = 4'd0; opa = 8'h10; opb = 8'h20; inp_valid = 2'b11;
        step();
        inp_valid = 2'b00;
        step();
        check("ce_rv_set", 32'(res_valid), 32'd1);
        ce = 1'b0;
        step();
        step();
        check("ce_rv_hold", 32'(res_valid), 32'd1);
        check("ce_res_hold", 32'(res), 32'h0030);
        ce = 1'b1;
        step();
        check("ce_rv_drop", 32'(res_valid), 32'd0);

        // reset while waiting for opb discards the operation
        mode = 1'b1; cmd = 4'd0; opa = 8'h09; inp_valid = 2'b01;
        step();
        inp_valid = 2'b00;
        step();
        #2 rst = 1'b0;
        #1;
        check("rst_async_res", 32'(res), 32'd0);
        check("rst_async_ready", 32'(ready), 32'd1);
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("rst_no_rv", 32'(res_valid), 32'd0);
        do_op("post_rst_add", 1'b1, 0, 1'b0, 'h03, 'h04, 0, 0);
        check("post_rst_const", 32'(res), 32'h0007);

        // timeout: 16 ce-high cycles without opb, with a 3-cycle ce-low pause
        mode = 1'b1; cmd = 4'd0; opa = 8'h11; opb = 8'h22; inp_valid = 2'b01;
        step();
        inp_valid = 2'b00;
        for (int i = 0; i < 8; i++) begin junk(); step(); end
        ce = 1'b0;
        for (int i = 0; i < 3; i++) step();
        ce = 1'b1;
        for (int i = 0; i < 7; i++) begin junk(); step(); end
        check("tmo_early", 32'(res_valid), 32'd0);
        step();
        check("tmo_rv", 32'(res_valid), 32'd1);
        check("tmo_res", 32'(res), 32'd0);
        check("tmo_flags", 32'({cout, oflow, g, l, e, err}), 32'd1);
        step();
        check("tmo_ready", 32'(ready), 32'd1);
        check("tmo_rv_drop", 32'(res_valid), 32'd0);

        do_op("rotl_ok", 1'b0, 12, 1'b0, 'h81, 'h01, 0, 0);
        check("rotl_ok_const", 32'({res, err}), 32'h0006);
        do_op("rotl_bad", 1'b0, 12, 1'b0, 'h81, 'h10, 0, 0);
        check("rotl_bad_const", 32'({res, err}), 32'h0001);
        do_op("sadd_ovf", 1'b1, 11, 1'b0, 'h7F, 'h01, 2, 2);
        check("sadd_ovf_const", 32'({res, oflow}), 32'h1FF01);

`ifdef ALU_MUL_EN
        do_op("mul_shl", 1'b1, 10, 1'b0, 'h80, 'h02, 0, 0);
        check("mul_shl_const", 32'(res), 32'h0200);
        do_op("mul_inc", 1'b1, 9, 1'b0, 'hFF, 'hFF, 0, 0);
        check("mul_inc_const", 32'(res), 32'h0000);
`else
        do_op("nomul_9", 1'b1, 9, 1'b0, 'hFF, 'hFF, 0, 0);
        check("nomul_9_err", 32'(err), 32'd1);
`endif

        for (int n = 0; n < 80; n++) begin
            do_op("rnd", 1'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
                  int'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 5)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
